// File: rtl/sound_mixer_multi.sv
// sound_mixer_multi
// Multi-channel square-wave tone generator. Each channel has a programmable
// half-period, a duration timer counted in prescaler ticks, and a volume.
// The gated channel volumes are summed into a registered PCM sample, and a
// first-order delta-sigma modulator turns that sample into a 1-bit speaker
// bitstream.
//
// Optional feature: define SOUND_MIXER_NOISE_EN to give every channel a
// 15-bit Galois LFSR noise source, selected by CONTROL bit2.
//
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-high reset
//   wr_en    - one-cycle register write strobe
//   wr_chan  - target channel (values >= CHANNELS are ignored)
//   wr_reg   - 0 PERIOD, 1 DURATION, 2 CONTROL, 3 ignored
//   wr_data  - write data
//   busy     - per-channel playing flag
//   pcm      - mixed sample
//   speaker  - delta-sigma bitstream
module sound_mixer_multi #(
    parameter int CHANNELS = 4,
    parameter int PERIOD_W = 16,
    parameter int DUR_W    = 16,
    parameter int VOL_W    = 4,
    parameter int PRESCALE = 1024,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int PCM_W   = VOL_W + $clog2(CHANNELS) + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_chan,
    input  logic [1:0]          wr_reg,
    input  logic [15:0]         wr_data,
    output logic [CHANNELS-1:0] busy,
    output logic [PCM_W-1:0]    pcm,
    output logic                speaker
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [1:0] REG_PERIOD   = 2'd0;
    localparam logic [1:0] REG_DURATION = 2'd1;
    localparam logic [1:0] REG_CONTROL  = 2'd2;

    typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} chanState_e;

    logic [PS_W-1:0]                 presc_q;
    logic                            tick;
    logic [CHANNELS-1:0][VOL_W-1:0]  chanLevel;
    logic [PCM_W-1:0]                mixSum;
    logic [PCM_W-1:0]                pcm_q;
    logic [PCM_W:0]                  acc_q;
    logic [PCM_W:0]                  accSum;
    logic                            speaker_q;
    logic                            unused_wrData;

    // Not every data bit is meaningful for every register.
    assign unused_wrData = ^wr_data;

    // Free-running prescaler shared by all duration timers; it is not
    // restarted by START, which is why the first tick of a note can land
    // anywhere within one prescaler period.
    assign tick = (presc_q == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk) begin
        if (reset)     presc_q <= '0;
        else if (tick) presc_q <= '0;
        else           presc_q <= presc_q + PS_W'(1);
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        chanState_e          state_q, state_d;
        logic [PERIOD_W-1:0] period_q, period_d, phase_q, phase_d;
        logic [DUR_W-1:0]    duration_q, duration_d, durCnt_q, durCnt_d;
        logic [VOL_W-1:0]    vol_q, vol_d;
        logic                square_q, square_d;
        logic                sel, halfDone, flipVal;

        assign sel      = wr_en && (int'(wr_chan) == i);
        // The >= compare lets a period shrunk mid-note expire at once
        // instead of counting all the way around the counter.
        assign halfDone = (phase_q >= (period_q - PERIOD_W'(1)));

`ifdef SOUND_MIXER_NOISE_EN
        logic [14:0] lfsr_q, lfsr_d, lfsrNext;
        logic        noise_q, noise_d;
        // Right-shifting Galois form of x^15 + x^14 + 1.
        assign lfsrNext = {1'b0, lfsr_q[14:1]} ^ (lfsr_q[0] ? 15'h6000 : 15'h0000);
        assign flipVal  = noise_q ? lfsrNext[0] : ~square_q;
`else
        assign flipVal  = ~square_q;
`endif

        // Tone and duration advance first; a register write in the same
        // cycle then overrides, with STOP taking priority over START.
        always_comb begin
            state_d    = state_q;
            period_d   = period_q;
            duration_d = duration_q;
            vol_d      = vol_q;
            phase_d    = phase_q;
            durCnt_d   = durCnt_q;
            square_d   = square_q;
`ifdef SOUND_MIXER_NOISE_EN
            lfsr_d     = lfsr_q;
            noise_d    = noise_q;
`endif
            if (state_q == PLAY) begin
                if (period_q == '0) begin
                    square_d = 1'b0;
                    phase_d  = '0;
                end else if (halfDone) begin
                    square_d = flipVal;
                    phase_d  = '0;
`ifdef SOUND_MIXER_NOISE_EN
                    if (noise_q) lfsr_d = lfsrNext;
`endif
                end else begin
                    phase_d = phase_q + PERIOD_W'(1);
                end
                // A zero count means the note plays until STOP.
                if (tick && durCnt_q != '0) begin
                    if (durCnt_q == DUR_W'(1)) begin
                        state_d  = IDLE;
                        square_d = 1'b0;
                        phase_d  = '0;
                    end
                    durCnt_d = durCnt_q - DUR_W'(1);
                end
            end
            if (sel && wr_reg == REG_PERIOD)   period_d   = wr_data[PERIOD_W-1:0];
            if (sel && wr_reg == REG_DURATION) duration_d = wr_data[DUR_W-1:0];
            if (sel && wr_reg == REG_CONTROL) begin
                vol_d = wr_data[4 +: VOL_W];
`ifdef SOUND_MIXER_NOISE_EN
                noise_d = wr_data[2];
`endif
                if (wr_data[1]) begin
                    state_d  = IDLE;
                    square_d = 1'b0;
                    phase_d  = '0;
                end else if (wr_data[0]) begin
                    state_d  = PLAY;
                    square_d = 1'b0;
                    phase_d  = '0;
                    durCnt_d = duration_q;
`ifdef SOUND_MIXER_NOISE_EN
                    lfsr_d   = 15'h0001;
`endif
                end
            end
        end

        // Channel state registers.
        always_ff @(posedge clk) begin
            if (reset) begin
                state_q    <= IDLE;
                period_q   <= '0;
                duration_q <= '0;
                vol_q      <= '0;
                phase_q    <= '0;
                durCnt_q   <= '0;
                square_q   <= 1'b0;
`ifdef SOUND_MIXER_NOISE_EN
                lfsr_q     <= 15'h0001;
                noise_q    <= 1'b0;
`endif
            end else begin
                state_q    <= state_d;
                period_q   <= period_d;
                duration_q <= duration_d;
                vol_q      <= vol_d;
                phase_q    <= phase_d;
                durCnt_q   <= durCnt_d;
                square_q   <= square_d;
`ifdef SOUND_MIXER_NOISE_EN
                lfsr_q     <= lfsr_d;
                noise_q    <= noise_d;
`endif
            end
        end

        assign busy[i]      = (state_q == PLAY);
        assign chanLevel[i] = ((state_q == PLAY) && square_q) ? vol_q : '0;
    end

    // Mixer adder tree; PCM_W is wide enough for every channel at full scale.
    always_comb begin
        mixSum = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            mixSum = mixSum + PCM_W'(chanLevel[c]);
        end
    end

    // The carry out of the accumulator becomes the next speaker bit, so the
    // ones-density tracks pcm / 2^PCM_W.
    assign accSum = {1'b0, acc_q[PCM_W-1:0]} + {1'b0, pcm_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            pcm_q     <= '0;
            acc_q     <= '0;
            speaker_q <= 1'b0;
        end else begin
            pcm_q     <= mixSum;
            acc_q     <= accSum;
            speaker_q <= accSum[PCM_W];
        end
    end

    assign pcm     = pcm_q;
    assign speaker = speaker_q;
endmodule

// File: tb/tb_sound_mixer_multi.sv
module tb_sound_mixer_multi;
    localparam int NCH  = 4;
    localparam int PRE  = 16;
    localparam int MODW = 128;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_en = 1'b0;
    logic [1:0]  wr_chan = '0;
    logic [1:0]  wr_reg = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  busy;
    logic [6:0]  pcm;
    logic        speaker;

    int errCount = 0;
    int checkCount = 0;

    // Behavioural reference state: per-channel note bookkeeping in plain ints.
    int mPlay[NCH], mSq[NCH], mPhase[NCH], mPer[NCH], mDur[NCH], mCnt[NCH], mVol[NCH];
    int mPcm, mAcc, mSpk, mCycles;

    sound_mixer_multi #(
        .CHANNELS(NCH), .PERIOD_W(16), .DUR_W(16), .VOL_W(4), .PRESCALE(PRE)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_chan(wr_chan),
        .wr_reg(wr_reg), .wr_data(wr_data), .busy(busy), .pcm(pcm), .speaker(speaker)
    );

    always #5 clk = ~clk;

    // Advance the reference by one clock using the inputs presented at the edge.
    task automatic modelStep();
        int newPcm, accN, c;
        bit tk;
        if (reset) begin
            for (int k = 0; k < NCH; k++) begin
                mPlay[k] = 0; mSq[k] = 0; mPhase[k] = 0; mPer[k] = 0;
                mDur[k] = 0; mCnt[k] = 0; mVol[k] = 0;
            end
            mPcm = 0; mAcc = 0; mSpk = 0; mCycles = 0;
            return;
        end
        newPcm = 0;
        for (int k = 0; k < NCH; k++) if (mPlay[k] != 0 && mSq[k] != 0) newPcm += mVol[k];
        accN = (mAcc % MODW) + mPcm;
        mSpk = (accN >= MODW) ? 1 : 0;
        mAcc = accN;
        mPcm = newPcm;
        tk = ((mCycles % PRE) == PRE - 1);
        mCycles++;
        for (int k = 0; k < NCH; k++) begin
            if (mPlay[k] != 0) begin
                if (mPer[k] == 0) begin
                    mSq[k] = 0; mPhase[k] = 0;
                end else if (mPhase[k] >= mPer[k] - 1) begin
                    mSq[k] = 1 - mSq[k]; mPhase[k] = 0;
                end else begin
                    mPhase[k]++;
                end
                if (tk && mCnt[k] != 0) begin
                    if (mCnt[k] == 1) begin
                        mPlay[k] = 0; mSq[k] = 0; mPhase[k] = 0;
                    end
                    mCnt[k]--;
                end
            end
        end
        if (wr_en) begin
            c = int'(wr_chan);
            if (wr_reg == 2'd0) mPer[c] = int'(wr_data);
            if (wr_reg == 2'd1) mDur[c] = int'(wr_data);
            if (wr_reg == 2'd2) begin
                mVol[c] = (int'(wr_data) >> 4) & 15;
                if (wr_data[1]) begin
                    mPlay[c] = 0; mSq[c] = 0; mPhase[c] = 0;
                end else if (wr_data[0]) begin
                    mPlay[c] = 1; mSq[c] = 0; mPhase[c] = 0; mCnt[c] = mDur[c];
                end
            end
        end
    endtask

    function automatic logic [3:0] expBusy();
        logic [3:0] b;
        for (int k = 0; k < NCH; k++) b[k] = (mPlay[k] != 0);
        return b;
    endfunction

    task automatic stepClk();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic applyStimulus(input int ch, input int rg, input int dat);
        wr_en = 1'b1; wr_chan = 2'(ch); wr_reg = 2'(rg); wr_data = 16'(dat);
        stepClk();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        stepClk();
        stepClk();
        reset = 1'b0;
        checkCount++; if (busy !== 4'b0000) begin errCount++; $display("[TB] FAIL reset_busy got=%b want=0000", busy); end
        checkCount++; if (pcm !== 7'd0) begin errCount++; $display("[TB] FAIL reset_pcm got=%0d want=0", pcm); end
        checkCount++; if (speaker !== 1'b0) begin errCount++; $display("[TB] FAIL reset_speaker got=%b want=0", speaker); end
    endtask

    task automatic test_tone();
        int t, rise1, rise2, prev;
        applyStimulus(0, 0, 4);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 2, 'h0F1);
        rise1 = -1; rise2 = -1; prev = int'(pcm);
        for (t = 0; t < 40; t++) begin
            stepClk();
            checkCount++; if (pcm !== 7'(mPcm)) begin errCount++; $display("[TB] FAIL tone_pcm t=%0d got=%0d want=%0d", t, pcm, mPcm); end
            checkCount++; if (busy !== 4'b0001) begin errCount++; $display("[TB] FAIL tone_busy t=%0d got=%b want=0001", t, busy); end
            if (prev == 0 && pcm == 7'd15) begin
                if (rise1 < 0) rise1 = t; else if (rise2 < 0) rise2 = t;
            end
            prev = int'(pcm);
        end
        checkCount++; if (rise2 - rise1 != 8 || rise1 < 0) begin errCount++; $display("[TB] FAIL tone_period got=%0d want=8", rise2 - rise1); end
        applyStimulus(0, 2, 'h002);
    endtask

    task automatic test_duration();
        int k;
        applyStimulus(1, 0, 2);
        applyStimulus(1, 1, 3);
        applyStimulus(1, 2, 'h0F1);
        k = 0;
        while (k < 100) begin
            stepClk();
            k++;
            checkCount++; if (busy !== expBusy()) begin errCount++; $display("[TB] FAIL dur_busy_model got=%b want=%b", busy, expBusy()); end
            if (busy[1] == 1'b0) break;
        end
        checkCount++; if (k < 33 || k > 48) begin errCount++; $display("[TB] FAIL dur_length got=%0d want=33..48", k); end
        stepClk();
        checkCount++; if (pcm !== 7'd0) begin errCount++; $display("[TB] FAIL dur_pcm_zero got=%0d want=0", pcm); end
    endtask

    task automatic test_stop_start();
        int maxPcm;
        applyStimulus(0, 0, 4);
        applyStimulus(1, 0, 4);
        applyStimulus(1, 1, 0);
        applyStimulus(0, 2, 'h0F1);
        applyStimulus(1, 2, 'h0F1);
        repeat (10) stepClk();
        applyStimulus(1, 2, 'h0F3);
        checkCount++; if (busy !== 4'b0001) begin errCount++; $display("[TB] FAIL stopstart_busy got=%b want=0001", busy); end
        maxPcm = 0;
        for (int t = 0; t < 20; t++) begin
            stepClk();
            if (int'(pcm) > maxPcm) maxPcm = int'(pcm);
            checkCount++; if (pcm !== 7'(mPcm)) begin errCount++; $display("[TB] FAIL stopstart_pcm got=%0d want=%0d", pcm, mPcm); end
        end
        checkCount++; if (maxPcm != 15) begin errCount++; $display("[TB] FAIL stopstart_max got=%0d want=15", maxPcm); end
        applyStimulus(0, 2, 'h002);
    endtask

    task automatic test_all_channels();
        int maxPcm, ones, sumPcm, diff;
        for (int c = 0; c < NCH; c++) begin
            applyStimulus(c, 0, 10);
            applyStimulus(c, 1, 0);
        end
        for (int c = 0; c < NCH; c++) applyStimulus(c, 2, 'h0F1);
        maxPcm = 0; ones = 0; sumPcm = 0;
        for (int t = 0; t < 128; t++) begin
            stepClk();
            if (int'(pcm) > maxPcm) maxPcm = int'(pcm);
            sumPcm += int'(pcm);
            if (speaker) ones++;
            checkCount++; if (speaker !== 1'(mSpk)) begin errCount++; $display("[TB] FAIL all_speaker t=%0d got=%b want=%0d", t, speaker, mSpk); end
        end
        checkCount++; if (maxPcm != 60) begin errCount++; $display("[TB] FAIL all_peak got=%0d want=60", maxPcm); end
        diff = ones * MODW - sumPcm;
        checkCount++; if (diff > 2 * MODW || diff < -2 * MODW) begin errCount++; $display("[TB] FAIL all_density ones=%0d sumPcm=%0d", ones, sumPcm); end
        for (int c = 0; c < NCH; c++) applyStimulus(c, 2, 'h002);
    endtask

    task automatic test_period_shrink();
        int prev, k;
        applyStimulus(2, 0, 100);
        applyStimulus(2, 1, 0);
        applyStimulus(2, 2, 'h0F1);
        repeat (50) stepClk();
        applyStimulus(2, 0, 20);
        stepClk();
        checkCount++; if (pcm !== 7'd0) begin errCount++; $display("[TB] FAIL shrink_pre got=%0d want=0", pcm); end
        stepClk();
        checkCount++; if (pcm !== 7'd15) begin errCount++; $display("[TB] FAIL shrink_toggle got=%0d want=15", pcm); end
        prev = int'(pcm); k = 0;
        while (k < 100) begin
            stepClk();
            k++;
            if (prev == 0 && pcm == 7'd15) break;
            prev = int'(pcm);
        end
        checkCount++; if (k != 40) begin errCount++; $display("[TB] FAIL shrink_period got=%0d want=40", k); end
        applyStimulus(2, 2, 'h002);
    endtask

    task automatic test_random();
        int rg, dat;
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(3) == 0) begin
                rg = int'($urandom_range(3));
                case (rg)
                    0: dat = int'($urandom_range(12));
                    1: dat = int'($urandom_range(6));
                    default: dat = int'($urandom) & 'hFFFF;
                endcase
                if (rg == 2 && $urandom_range(2) == 0) dat = dat & 'hFFFD;
                wr_en = 1'b1; wr_chan = 2'($urandom_range(3)); wr_reg = 2'(rg); wr_data = 16'(dat);
            end else begin
                wr_en = 1'b0;
            end
            stepClk();
            checkCount++; if (busy !== expBusy()) begin errCount++; $display("[TB] FAIL rand_busy t=%0d got=%b want=%b", t, busy, expBusy()); end
            checkCount++; if (pcm !== 7'(mPcm)) begin errCount++; $display("[TB] FAIL rand_pcm t=%0d got=%0d want=%0d", t, pcm, mPcm); end
            checkCount++; if (speaker !== 1'(mSpk)) begin errCount++; $display("[TB] FAIL rand_speaker t=%0d got=%b want=%0d", t, speaker, mSpk); end
        end
        wr_en = 1'b0;
    endtask

    task automatic test_reset_mid_note();
        for (int c = 0; c < NCH; c++) begin
            applyStimulus(c, 0, 3);
            applyStimulus(c, 2, 'h0F1);
        end
        repeat (20) stepClk();
        reset = 1'b1;
        wr_en = 1'b1; wr_chan = 2'd0; wr_reg = 2'd0; wr_data = 16'd5;
        stepClk();
        reset = 1'b0; wr_en = 1'b0;
        checkCount++; if (busy !== 4'b0000) begin errCount++; $display("[TB] FAIL midreset_busy got=%b want=0000", busy); end
        checkCount++; if (pcm !== 7'd0) begin errCount++; $display("[TB] FAIL midreset_pcm got=%0d want=0", pcm); end
        checkCount++; if (speaker !== 1'b0) begin errCount++; $display("[TB] FAIL midreset_speaker got=%b want=0", speaker); end
        applyStimulus(0, 2, 'h0F1);
        for (int t = 0; t < 20; t++) begin
            stepClk();
            checkCount++; if (pcm !== 7'd0) begin errCount++; $display("[TB] FAIL midreset_write_ignored t=%0d got=%0d want=0", t, pcm); end
        end
        checkCount++; if (busy !== 4'b0001) begin errCount++; $display("[TB] FAIL midreset_restart_busy got=%b want=0001", busy); end
    endtask

    initial begin
        $display("[TB] sound_mixer_multi bench start");
        test_reset();
        test_tone();
        test_duration();
        test_stop_start();
        test_all_channels();
        test_period_shrink();
        test_random();
        test_reset_mid_note();
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end
endmodule
